// File: rtl/posit_normalizer.sv
// posit_normalizer: left-normalizes a posit mantissa sum, adjusting regime/exponent, with zero and saturation flags
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   in_valid / in_ready            input handshake; a tuple is captured only in IDLE
//   in_sign, in_mantissa           sign and unsigned 8-bit mantissa sum
//   in_regime, in_exponent         signed interim regime k and exponent e (e in -1..2^EN-1)
//   out_valid / out_ready          output handshake; outputs are held until accepted
//   out_sign, out_mantissa         sign passthrough, normalized mantissa (bit 7 = hidden one)
//   out_regime, out_exponent       normalized regime and exponent (0..2^EN-1)
//   out_zero, out_sat              exact-zero result, regime clamped on over/underflow
module posit_normalizer #(
    parameter int WIDTH = 7,
    parameter int EN    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_sign,
    input  logic [7:0] in_mantissa,
    input  logic [7:0] in_regime,
    input  logic [7:0] in_exponent,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_sign,
    output logic [7:0] out_mantissa,
    output logic [7:0] out_regime,
    output logic [7:0] out_exponent,
    output logic       out_zero,
    output logic       out_sat
);
    localparam logic signed [8:0] K_MIN = 9'(-WIDTH);
    localparam logic signed [8:0] K_MAX = 9'(WIDTH - 1);
    localparam logic signed [7:0] E_MAX = 8'((1 << EN) - 1);

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    state_t state, state_n;
    logic [7:0] m, m_n;
    logic signed [8:0] k, k_n;
    logic signed [7:0] e, e_n;
    logic s, s_n, z, z_n, sat, sat_n;

    // k is kept 9 bits wide so a regime of -128 minus one cannot wrap past the clamp compare
    logic signed [8:0] k_fold, k_dec;
    logic signed [7:0] e_fold, e_dec, e_sub;
    logic e_wrap;

    always_comb begin
        k_fold = $signed({in_regime[7], in_regime}) - (in_exponent[7] ? 9'sd1 : 9'sd0);
        e_fold = in_exponent[7] ? $signed(in_exponent) + E_MAX + 8'sd1 : $signed(in_exponent);
        e_sub  = e - 8'sd1;
        e_wrap = e_sub[7];
        e_dec  = e_wrap ? E_MAX : e_sub;
        k_dec  = e_wrap ? k - 9'sd1 : k;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            m     <= '0;
            k     <= '0;
            e     <= '0;
            s     <= 1'b0;
            z     <= 1'b0;
            sat   <= 1'b0;
        end else begin
            state <= state_n;
            m     <= m_n;
            k     <= k_n;
            e     <= e_n;
            s     <= s_n;
            z     <= z_n;
            sat   <= sat_n;
        end
    end

    always_comb begin
        state_n = state;
        m_n     = m;
        k_n     = k;
        e_n     = e;
        s_n     = s;
        z_n     = z;
        sat_n   = sat;
        case (state)
            IDLE: if (in_valid) begin
                s_n   = in_sign;
                z_n   = 1'b0;
                sat_n = 1'b0;
                if (in_mantissa == 8'h00) begin
                    z_n     = 1'b1;
                    m_n     = '0;
                    k_n     = '0;
                    e_n     = '0;
                    state_n = DONE;
                end else if (k_fold > K_MAX) begin
                    k_n     = K_MAX;
                    e_n     = E_MAX;
                    m_n     = 8'hFF;
                    sat_n   = 1'b1;
                    state_n = DONE;
                end else begin
                    m_n     = in_mantissa;
                    k_n     = k_fold;
                    e_n     = e_fold;
                    state_n = NORM;
                end
            end
            NORM: if (m[7]) begin
                state_n = DONE;
            end else if (k_dec < K_MIN) begin
                k_n     = K_MIN;
                e_n     = '0;
                m_n     = 8'h80;
                sat_n   = 1'b1;
                state_n = DONE;
            end else begin
                m_n = {m[6:0], 1'b0};
                e_n = e_dec;
                k_n = k_dec;
            end
            DONE: state_n = out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        in_ready     = state == IDLE;
        out_valid    = state == DONE;
        out_sign     = s;
        out_mantissa = m;
        out_regime   = k[7:0];
        out_exponent = e;
        out_zero     = z;
        out_sat      = sat;
    end
endmodule

// File: tb/tb_posit_normalizer.sv
// tb_posit_normalizer: directed-vector self-checking bench for posit_normalizer
module tb_posit_normalizer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_sign = 1'b0;
    logic [7:0] in_mantissa = '0;
    logic [7:0] in_regime = '0;
    logic [7:0] in_exponent = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_sign;
    logic [7:0] out_mantissa;
    logic [7:0] out_regime;
    logic [7:0] out_exponent;
    logic       out_zero;
    logic       out_sat;

    int n_cmp = 0;
    int n_bad = 0;

    posit_normalizer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
        .in_mantissa(in_mantissa), .in_regime(in_regime), .in_exponent(in_exponent),
        .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
        .out_mantissa(out_mantissa), .out_regime(out_regime), .out_exponent(out_exponent),
        .out_zero(out_zero), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run(input string name, input logic s, input logic [7:0] mm, input logic [7:0] kk,
                       input logic [7:0] ee, input int lat_x, input logic [7:0] mx, input logic [7:0] kx,
                       input logic [7:0] ex, input logic zx, input logic satx, input logic hold);
        int lat;
        @(posedge clk); #1;
        chk({name, " in_ready idle"}, in_ready, 1);
        in_valid = 1'b1; in_sign = s; in_mantissa = mm; in_regime = kk; in_exponent = ee;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        chk({name, " latency"}, lat, lat_x);
        chk({name, " sign"}, out_sign, s);
        chk({name, " mant"}, out_mantissa, mx);
        chk({name, " regime"}, out_regime, kx);
        chk({name, " exp"}, out_exponent, ex);
        chk({name, " zero"}, out_zero, zx);
        chk({name, " sat"}, out_sat, satx);
        chk({name, " in_ready busy"}, in_ready, 0);
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1;
                in_valid = 1'b1; in_mantissa = 8'h55; in_sign = ~s;
                @(negedge clk);
                chk($sformatf("%s hold%0d valid", name, i), out_valid, 1);
                chk($sformatf("%s hold%0d in_ready", name, i), in_ready, 0);
                chk($sformatf("%s hold%0d data", name, i),
                    {out_sign, out_zero, out_sat, out_mantissa, out_regime, out_exponent},
                    {s, zx, satx, mx, kx, ex});
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({name, " drop valid"}, out_valid, 0);
        chk({name, " ready again"}, in_ready, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset valid", out_valid, 0);
        chk("reset ready", in_ready, 1);
        chk("reset data", {out_sign, out_zero, out_sat, out_mantissa, out_regime, out_exponent}, 0);
        rst = 1'b0;

        run("aligned",    1'b0, 8'h80, 8'h00, 8'h00, 2, 8'h80, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        run("two_shift",  1'b0, 8'h20, 8'h01, 8'h00, 4, 8'h80, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        run("fold",       1'b0, 8'h40, 8'h00, 8'hFF, 3, 8'h80, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        run("zero_hold",  1'b1, 8'h00, 8'h03, 8'h01, 1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
        run("underflow",  1'b0, 8'h01, 8'hF9, 8'h00, 2, 8'h80, 8'hF9, 8'h00, 1'b0, 1'b1, 1'b0);
        run("overflow",   1'b0, 8'h80, 8'h07, 8'h00, 1, 8'hFF, 8'h06, 8'h01, 1'b0, 1'b1, 1'b0);
        run("seven_shift",1'b1, 8'h01, 8'h03, 8'h01, 9, 8'h80, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        run("kmax_fold",  1'b0, 8'hC0, 8'h07, 8'hFF, 2, 8'hC0, 8'h06, 8'h01, 1'b0, 1'b0, 1'b0);
        run("late_uflow", 1'b0, 8'h01, 8'hFA, 8'h01, 5, 8'h80, 8'hF9, 8'h00, 1'b0, 1'b1, 1'b0);

        @(posedge clk); #1;
        in_valid = 1'b1; in_sign = 1'b0; in_mantissa = 8'h02; in_regime = 8'h00; in_exponent = 8'h00;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("abort valid", out_valid, 0);
        chk("abort ready", in_ready, 1);
        #2;
        rst = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            chk("abort no output", seen, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/posit_normalizer.md
Name: posit_normalizer

Overview:
- Pipeline stage directly downstream of the mantissa adder in the posit ALU add path.
- Consumes the raw 8-bit mantissa sum and the interim regime/exponent.
- Iteratively left-normalizes the sum so that bit 7 is the hidden one, adjusting exponent and regime per shift with exponent wrap.
- Emits a normalized (sign, regime, exponent, mantissa) tuple for the posit encoder, with zero and saturation flags. Valid/ready on both sides.

Parameters:
- WIDTH, 7: posit width minus sign bit. Legal regime range is K_MIN = -WIDTH to K_MAX = WIDTH-1.
- EN, 1: exponent field bits (es). Exponent range is 0 to 2^EN-1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input tuple valid
- in_ready  out  1  stage can accept a tuple
- in_sign  in  1  result sign (sign_t: POS=0, NEG=1)
- in_mantissa  in  8  unsigned mantissa sum
- in_regime  in  8  signed interim regime k
- in_exponent  in  8  signed interim exponent e, range -1 to 2^EN-1
- out_valid  out  1  output tuple valid
- out_ready  in  1  consumer accepts
- out_sign  out  1  sign
- out_mantissa  out  8  normalized mantissa; bit 7 = hidden one unless zero
- out_regime  out  8  signed normalized regime
- out_exponent  out  8  normalized exponent, 0 to 2^EN-1
- out_zero  out  1  result is exactly zero
- out_sat  out  1  regime clamped (over/underflow)

Behaviour:
- Encoding: in_mantissa bit 7 has weight 2^(k*2^EN + e). Each left shift reduces the scale by 1.
- Reset (async, immediate): state IDLE; in_ready=1; out_valid=0; all out_* data and flags = 0.
- FSM states: IDLE, NORM, DONE.
- IDLE:
  - in_ready=1. Capture occurs on in_valid & in_ready.
  - On capture, fold the exponent: if e<0 then e += 2^EN and k -= 1.
  - If mantissa == 0: out_zero=1, mantissa/k/e = 0, go to DONE.
  - Else if folded k > K_MAX: clamp to k=K_MAX, e=2^EN-1, mantissa=0xFF, out_sat=1, go to DONE.
  - Else go to NORM.
- NORM: in_ready=0. Each cycle:
  - If mantissa[7]=1, go to DONE.
  - Else shift mantissa left 1 (zero fill), e -= 1; if e<0 then e = 2^EN-1 and k -= 1.
  - If the new k < K_MIN: output k=K_MIN, e=0, mantissa=0x80, out_sat=1, go to DONE.
- DONE: out_valid=1. Outputs are registered and stable until out_ready. On out_valid & out_ready, go to IDLE and drop out_valid the next cycle.
- Latency:
  - Zero or overflow: 1 cycle from capture to out_valid.
  - Otherwise: 2 + lz cycles, where lz = leading zeros of in_mantissa (0 to 7).
- Throughput: one tuple in flight; no capture until the DONE handshake completes. There is no same-cycle IDLE re-entry capture.
- out_sign passes through unchanged, including for zero results.
- Arithmetic: all regime/exponent math is 8-bit signed two's complement. Intermediate k is held in 9 bits so the clamp compare cannot wrap.
- in_* inputs are ignored outside IDLE.
- Reset asserted in NORM or DONE aborts the operation; the pending tuple is discarded and never emitted.

Test Plan:
- mantissa=0x80, k=0, e=0, sign=0 -> out_valid 2 cycles after capture; mant 0x80, k 0, e 0, zero 0, sat 0.
- mantissa=0x20, k=1, e=0 -> 2 shifts, latency 4; mant 0x80, k 0, e 0.
- mantissa=0x40, k=0, e=-1 -> fold to k=-1, e=1; 1 shift; mant 0x80, k -1, e 0.
- mantissa=0x00, sign=1 -> latency 1; zero 1, sign 1, mant 0, k 0, e 0. Then hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0 throughout.
- mantissa=0x01, k=-7, e=0 -> first shift gives k=-8, clamped to k -7, e 0, mant 0x80, sat 1. Separately, k=7, e=0 -> k 6, e 1, mant 0xFF, sat 1.
- mantissa=0x02 captured, rst pulsed mid-NORM (asynchronous, between clock edges) -> out_valid=0 immediately, in_ready=1; no output ever appears for that tuple.
